// File: rtl/lwir_frame_sequencer_if.sv
// Signal bundle between the sensor/compressor environment and lwir_frame_sequencer.
// slave is the sequencer's view; master is the environment's view.
interface lwir_frame_sequencer_if;
    logic        valid_in;
    logic        sof_in;
    logic [15:0] pixel_in;
    logic        ready_out;
    logic        comp_valid_out;
    logic [15:0] comp_pixel_out;
    logic        comp_valid_in;
    logic [31:0] comp_stream_in;
    logic        valid_out;
    logic [31:0] stream_out;
    logic        frame_done;
    logic        frame_err;

    modport slave (
        input  valid_in, sof_in, pixel_in, comp_valid_in, comp_stream_in,
        output ready_out, comp_valid_out, comp_pixel_out, valid_out, stream_out,
        frame_done, frame_err
    );

    modport master (
        output valid_in, sof_in, pixel_in, comp_valid_in, comp_stream_in,
        input  ready_out, comp_valid_out, comp_pixel_out, valid_out, stream_out,
        frame_done, frame_err
    );
endinterface

// File: rtl/lwir_frame_sequencer.sv
// Frame-level controller for the LWIR lossless compressor: gates one frame of pixels into the
// core, waits for it to drain, and wraps the core's output stream in header/trailer words.
module lwir_frame_sequencer #(
    parameter int unsigned IMG_W        = 640,
    parameter int unsigned IMG_H        = 512,
    parameter int unsigned DRAIN_CYCLES = 8,
    parameter logic [15:0] MAGIC        = 16'hA5C3
) (
    input  logic                         clk,
    input  logic                         rst,
    lwir_frame_sequencer_if.slave        bus
);
    localparam int unsigned FRAME_PIX = IMG_W * IMG_H;
    localparam int unsigned PixW      = $clog2(FRAME_PIX + 1);
    localparam int unsigned IdleW     = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {StIdle, StHeader, StPixels, StDrain, StTrailer} state_e;

    state_e             state_q, state_d;
    logic [PixW-1:0]    pix_cnt_q, pix_cnt_d;
    logic [IdleW-1:0]   idle_cnt_q, idle_cnt_d;
    logic [19:0]        word_cnt_q, word_cnt_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic               trunc_q, trunc_d;
    logic               err_q, err_d;
    logic               valid_out_q, valid_out_d;
    logic [31:0]        stream_q, stream_d;
    logic               frame_done_q, frame_done_d;
    logic               comp_valid_q, comp_valid_d;
    logic [15:0]        comp_pixel_q, comp_pixel_d;
    logic               ready;
    logic               sof_req;
    logic               ctl_slot;

    assign sof_req  = bus.valid_in && bus.sof_in;
    // Header/trailer cycles own the output register; core words there are collisions.
    assign ctl_slot = (state_q == StHeader) || (state_q == StTrailer);

    always_comb begin
        state_d      = state_q;
        pix_cnt_d    = pix_cnt_q;
        idle_cnt_d   = '0;
        word_cnt_d   = word_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        trunc_d      = trunc_q;
        err_d        = err_q;
        valid_out_d  = 1'b0;
        stream_d     = stream_q;
        frame_done_d = 1'b0;
        comp_valid_d = 1'b0;
        comp_pixel_d = comp_pixel_q;
        ready        = 1'b0;

        if (bus.comp_valid_in) begin
            if (ctl_slot) begin
                err_d = 1'b1;
            end else begin
                valid_out_d = 1'b1;
                stream_d    = bus.comp_stream_in;
                if (word_cnt_q != 20'hFFFFF) begin
                    word_cnt_d = word_cnt_q + 20'd1;
                end
            end
        end

        unique case (state_q)
            StIdle: begin
                ready = !sof_req;
                if (sof_req) begin
                    state_d = StHeader;
                end
            end
            StHeader: begin
                valid_out_d = 1'b1;
                stream_d    = {MAGIC, frame_cnt_q};
                state_d     = StPixels;
            end
            StPixels: begin
                ready = (pix_cnt_q == '0) || !sof_req;
                if (sof_req && (pix_cnt_q != '0)) begin
                    // Leave the SOF pixel pending so it opens the next frame from idle.
                    trunc_d = 1'b1;
                    err_d   = 1'b1;
                    state_d = StDrain;
                end else if (bus.valid_in) begin
                    comp_valid_d = 1'b1;
                    comp_pixel_d = bus.pixel_in;
                    pix_cnt_d    = pix_cnt_q + 1'b1;
                    if (pix_cnt_q == PixW'(FRAME_PIX - 1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (!bus.comp_valid_in) begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
                if (idle_cnt_d == IdleW'(DRAIN_CYCLES)) begin
                    state_d = StTrailer;
                end
            end
            StTrailer: begin
                valid_out_d  = 1'b1;
                stream_d     = {8'h5A, 3'b000, trunc_q, word_cnt_q};
                frame_done_d = 1'b1;
                frame_cnt_d  = frame_cnt_q + 16'd1;
                pix_cnt_d    = '0;
                word_cnt_d   = '0;
                trunc_d      = 1'b0;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            pix_cnt_q    <= '0;
            idle_cnt_q   <= '0;
            word_cnt_q   <= '0;
            frame_cnt_q  <= '0;
            trunc_q      <= 1'b0;
            err_q        <= 1'b0;
            valid_out_q  <= 1'b0;
            stream_q     <= '0;
            frame_done_q <= 1'b0;
            comp_valid_q <= 1'b0;
            comp_pixel_q <= '0;
        end else begin
            state_q      <= state_d;
            pix_cnt_q    <= pix_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            word_cnt_q   <= word_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            trunc_q      <= trunc_d;
            err_q        <= err_d;
            valid_out_q  <= valid_out_d;
            stream_q     <= stream_d;
            frame_done_q <= frame_done_d;
            comp_valid_q <= comp_valid_d;
            comp_pixel_q <= comp_pixel_d;
        end
    end

    assign bus.ready_out      = ready;
    assign bus.comp_valid_out = comp_valid_q;
    assign bus.comp_pixel_out = comp_pixel_q;
    assign bus.valid_out      = valid_out_q;
    assign bus.stream_out     = stream_q;
    assign bus.frame_done     = frame_done_q;
    assign bus.frame_err      = err_q;

endmodule
